// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbitrated shared counter (inc/dec/clear/read) with a grant/ack handshake
// Ports: clock; reset (async, active low); req/op per requester; grant/ack one-hot, registered;
// data_o shared counter; busy = FSM not idle; wrap = one-cycle pulse in ACK on inc/dec overflow.
module counter_scheduler #(
  parameter int Requesters = 4,
  parameter int Size = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [Requesters-1:0]     req,
  input  logic [2*Requesters-1:0]   op,
  output logic [Requesters-1:0]     grant,
  output logic [Requesters-1:0]     ack,
  output logic [Size-1:0]           data_o,
  output logic                      busy,
  output logic                      wrap
);
  localparam int W = $clog2(Requesters);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2;
  localparam logic [Requesters-1:0] one = 1;
  logic [1:0] state;
  logic [W-1:0] last, w, pick;
  logic [W:0] cand;
  logic found;
  logic [1:0] cur_op;
  // candidates are visited from last+1 upward with wrap; the first requesting one wins
  always_comb begin
    pick = last;
    found = 1'b0;
    cand = '0;
    for (int i = 0; i < Requesters; i++) begin
      cand = {1'b0, last} + (W+1)'(i + 1);
      if (cand >= (W+1)'(Requesters)) cand = cand - (W+1)'(Requesters);
      if (!found && req[cand[W-1:0]]) begin
        pick = cand[W-1:0];
        found = 1'b1;
      end
    end
  end
  assign cur_op = op[{w, 1'b0} +: 2];
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last <= W'(Requesters - 1);
      w <= '0;
      grant <= '0;
      ack <= '0;
      data_o <= '0;
      wrap <= '0;
    end else begin
      grant <= '0;
      ack <= '0;
      wrap <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          w <= pick;
          grant <= one << pick;
          state <= GRANT;
        end
        GRANT: if (req[w]) begin
          state <= ACK;
          ack <= one << w;
          last <= w;
          data_o <= cur_op == 2'b00 ? data_o + 1'b1 :
                    cur_op == 2'b01 ? data_o - 1'b1 :
                    cur_op == 2'b10 ? '0 : data_o;
          wrap <= (cur_op == 2'b00 && &data_o) || (cur_op == 2'b01 && ~|data_o);
        end else
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter Requesters, default 4, number of requesters sharing the counter (2..8).
REQ-002 Parameter Size, default 8, width of the shared counter.
REQ-003 Port clock  input  1  system clock; all state updates on posedge clock.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  Requesters  req[i] high = requester i has a pending operation; held until its ack.
REQ-006 Port op  input  2*Requesters  op[2i+1:2i] for requester i: 00 inc, 01 dec, 10 clear, 11 read (no change).
REQ-007 Port grant  output  Requesters  registered one-hot; marks the requester owning the counter.
REQ-008 Port ack  output  Requesters  registered one-hot, one-cycle pulse; operation of requester i completed.
REQ-009 Port data_o  output  Size  current shared counter value.
REQ-010 Port busy  output  1  high whenever the FSM is not IDLE.
REQ-011 Port wrap  output  1  one-cycle pulse when an operation wrapped the counter.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, GRANT, ACK.
REQ-013 IDLE: if any req bit is high at posedge, SHALL select winner w by round-robin and enter GRANT; else stay IDLE.
REQ-014 Round-robin: search SHALL start at index (last+1) mod Requesters and ascend with wrap; last = most recently acked requester.
REQ-015 last SHALL update only when an ack is issued; aborted grants SHALL NOT move it.
REQ-016 GRANT: grant[w] SHALL be high for exactly this one cycle; all other grant bits low.
REQ-017 GRANT with req[w] high: op[w] SHALL be sampled at the closing posedge, counter updated, FSM to ACK.
REQ-018 GRANT with req[w] low (withdrawn): no counter change, no ack, no wrap, FSM to IDLE.
REQ-019 ACK: ack[w] SHALL be high for exactly this one cycle; data_o already holds the updated value; FSM to IDLE.
REQ-020 inc SHALL compute data_o+1 mod 2^Size; dec SHALL compute data_o-1 mod 2^Size.
REQ-021 wrap SHALL pulse during the ACK cycle iff inc from all-ones or dec from zero.
REQ-022 clear SHALL set data_o to zero and never assert wrap; read SHALL leave data_o unchanged and still ack.
REQ-023 Req changes during ACK SHALL be ignored; IDLE resamples req at its own posedge.
REQ-024 Minimum spacing between accepted operations SHALL be 3 cycles (IDLE, GRANT, ACK).
REQ-025 Requesters SHALL drop req in the cycle after ack; a req still high in IDLE is a new operation.
REQ-026 op of non-granted requesters SHALL have no effect.

Reset
REQ-027 Reset low SHALL immediately force: FSM IDLE, data_o zero, grant zero, ack zero, busy zero, wrap zero, last = Requesters-1.
REQ-028 Reset during GRANT or ACK SHALL discard the operation with no ack, and the counter SHALL read zero.
REQ-029 After reset release the first arbitration SHALL favour requester 0.

Verification
REQ-030 Reset, req=0001, op0=inc -> grant=0001 in cycle 2, ack=0001 in cycle 3, data_o=1, wrap=0.
REQ-031 req=1111 held, all inc, ack each then re-request -> ack order 0,1,2,3,0; data_o counts 1..5.
REQ-032 data_o=255 (Size 8), inc -> data_o=0, wrap pulse with ack; then dec -> data_o=255, wrap pulse.
REQ-033 Requester 2 drops req during its GRANT -> no ack, data_o unchanged, next winner searched from 1+last.
REQ-034 data_o=7, op=clear -> data_o=0, wrap=0; op=read -> ack issued, data_o stays 0.
REQ-035 Assert reset low mid-GRANT -> all outputs zero asynchronously; after release req=0100 granted normally.
